// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - handshake, cell-control and status bundle for fifo_ctrl
//
// Purpose: groups the producer/consumer handshake, per-cell control strobes
// and FIFO status so they travel as a single port.
// Signals:
//   wr_req / wr_ack   producer write request / accept (ack is combinational)
//   rd_req / rd_ack   consumer read request / accept (ack is combinational)
//   flush_i           request to clear every cell
//   we_o              one-hot cell write enable
//   rsel_o            read cell index
//   clr_o             one-hot cell clear strobe
//   e_o               per-cell empty flags (1 = empty)
//   count_o           number of occupied cells
//   empty_o, full_o   FIFO empty / full
//   busy_o            flush sweep in progress
// Modports: master = the user side (drives requests), slave = fifo_ctrl.
interface fifo_ctrl_if #(
    parameter int N_CELLS = 16,
    parameter int PTR_W   = 4
);
    logic               wr_req;
    logic               wr_ack;
    logic               rd_req;
    logic               rd_ack;
    logic               flush_i;
    logic [N_CELLS-1:0] we_o;
    logic [PTR_W-1:0]   rsel_o;
    logic [N_CELLS-1:0] clr_o;
    logic [N_CELLS-1:0] e_o;
    logic [PTR_W:0]     count_o;
    logic               empty_o;
    logic               full_o;
    logic               busy_o;

    modport master (
        output wr_req, rd_req, flush_i,
        input  wr_ack, rd_ack, we_o, rsel_o, clr_o, e_o, count_o,
               empty_o, full_o, busy_o
    );

    modport slave (
        input  wr_req, rd_req, flush_i,
        output wr_ack, rd_ack, we_o, rsel_o, clr_o, e_o, count_o,
               empty_o, full_o, busy_o
    );
endinterface

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and flush-sweep controller for a cell FIFO
//
// Purpose: manages write/read pointers, per-cell empty flags and occupancy for
// an N_CELLS-deep FIFO whose storage lives outside this block. A flush walks
// every cell once, one per cycle, then returns everything to the reset state.
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset, highest priority
//   bus   fifo_ctrl_if.slave (handshake, cell strobes, status)
// Parameters:
//   N_CELLS  number of cells, 2..256 (need not be a power of two)
//   PTR_W    pointer width, ceil(log2(N_CELLS))
module fifo_ctrl #(
    parameter int N_CELLS = 16,
    parameter int PTR_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    fifo_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_CELLS - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(N_CELLS);

    state_t             r_state, w_state_nxt;
    logic [PTR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [PTR_W-1:0]   r_k, w_k_nxt;
    logic [PTR_W:0]     r_count, w_count_nxt;
    logic [N_CELLS-1:0] r_e, w_e_nxt;
    logic               r_empty, r_full;
    logic               w_in_flush;
    logic               w_wr_ack, w_rd_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_k      <= '0;
            r_count  <= '0;
            r_e      <= '1;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_k      <= w_k_nxt;
            r_count  <= w_count_nxt;
            r_e      <= w_e_nxt;
            // Flags are registered from next-state values so they line up
            // with e_o/count_o in the same cycle.
            r_empty  <= &w_e_nxt;
            r_full   <= (w_count_nxt == FULL_CNT);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_k_nxt      = r_k;
        w_count_nxt  = r_count;
        w_e_nxt      = r_e;

        w_in_flush = (r_state == FLUSH);
        // Full blocks writes and empty blocks reads, which also resolves the
        // simultaneous-request cases at the two extremes.
        w_wr_ack = bus.wr_req & ~r_full  & ~bus.flush_i & ~w_in_flush & ~rst;
        w_rd_ack = bus.rd_req & ~r_empty & ~bus.flush_i & ~w_in_flush & ~rst;

        case (r_state)
            IDLE, RUN: begin
                if (bus.flush_i) begin
                    w_state_nxt = FLUSH;
                    w_k_nxt     = '0;
                end else begin
                    if (w_wr_ack) begin
                        w_e_nxt[r_wr_ptr] = 1'b0;
                        w_wr_ptr_nxt = (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
                    end
                    if (w_rd_ack) begin
                        w_e_nxt[r_rd_ptr] = 1'b1;
                        w_rd_ptr_nxt = (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
                    end
                    case ({w_wr_ack, w_rd_ack})
                        2'b10:   w_count_nxt = r_count + 1'b1;
                        2'b01:   w_count_nxt = r_count - 1'b1;
                        default: w_count_nxt = r_count;
                    endcase
                    w_state_nxt = (w_count_nxt == '0) ? IDLE : RUN;
                end
            end
            FLUSH: begin
                w_e_nxt[r_k] = 1'b1;
                if (r_k == LAST_IDX) begin
                    w_state_nxt  = IDLE;
                    w_k_nxt      = '0;
                    w_wr_ptr_nxt = '0;
                    w_rd_ptr_nxt = '0;
                    w_count_nxt  = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.wr_ack  = w_wr_ack;
    assign bus.rd_ack  = w_rd_ack;
    assign bus.we_o    = w_wr_ack ? (N_CELLS'(1) << r_wr_ptr) : '0;
    assign bus.clr_o   = (w_in_flush && !rst) ? (N_CELLS'(1) << r_k) : '0;
    assign bus.rsel_o  = r_rd_ptr;
    assign bus.e_o     = r_e;
    assign bus.count_o = r_count;
    assign bus.empty_o = r_empty;
    assign bus.full_o  = r_full;
    assign bus.busy_o  = w_in_flush;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;
    localparam int N  = 16;
    localparam int PW = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fifo_ctrl_if #(.N_CELLS(N), .PTR_W(PW)) bus ();

    fifo_ctrl #(.N_CELLS(N), .PTR_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge, then settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.flush_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int wr_n;
        int rd_n;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.flush_i = 1'b0;
        tick();

        // Reset behaviour: acks and strobes held low while rst is high.
        bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.flush_i = 1'b1;
        #1;
        check("rst_wr_ack", bus.wr_ack, 0);
        check("rst_rd_ack", bus.rd_ack, 0);
        check("rst_we", bus.we_o, 0);
        check("rst_clr", bus.clr_o, 0);
        tick();
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.flush_i = 1'b0;
        rst = 1'b0;
        check("rst_e", bus.e_o, 32'hFFFF);
        check("rst_count", bus.count_o, 0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_full", bus.full_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_rsel", bus.rsel_o, 0);

        // Read from an empty FIFO is refused and changes nothing.
        bus.rd_req = 1'b1;
        #1;
        check("empty_rd_ack", bus.rd_ack, 0);
        tick();
        bus.rd_req = 1'b0;
        check("empty_rd_e", bus.e_o, 32'hFFFF);
        check("empty_rd_count", bus.count_o, 0);
        check("empty_rd_rsel", bus.rsel_o, 0);
        check("empty_rd_empty", bus.empty_o, 1);

        // Fill all 16 cells.
        for (int i = 0; i < N; i++) begin
            bus.wr_req = 1'b1;
            #1;
            check("fill_wr_ack", bus.wr_ack, 1);
            check("fill_we", bus.we_o, 32'(1) << i);
            tick();
        end
        check("full_count", bus.count_o, 16);
        check("full_flag", bus.full_o, 1);
        check("full_e", bus.e_o, 0);
        check("full_empty", bus.empty_o, 0);
        #1;
        check("wr17_ack", bus.wr_ack, 0);
        check("wr17_we", bus.we_o, 0);

        // Full with both requests: read only.
        bus.rd_req = 1'b1;
        #1;
        check("fullboth_rd_ack", bus.rd_ack, 1);
        check("fullboth_wr_ack", bus.wr_ack, 0);
        tick();
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        check("fullboth_count", bus.count_o, 15);
        check("fullboth_e", bus.e_o, 32'h0001);
        check("fullboth_empty", bus.empty_o, 0);
        check("fullboth_full", bus.full_o, 0);
        check("fullboth_rsel", bus.rsel_o, 1);

        // 20 writes interleaved with reads: 3 lead writes, then 17 write+read.
        do_reset();
        wr_n = 0; rd_n = 0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_req = 1'b1;
            tick();
            wr_n++;
        end
        bus.rd_req = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            check("ilv_rsel", bus.rsel_o, rd_n % N);
            check("ilv_we", bus.we_o, 32'(1) << (wr_n % N));
            check("ilv_acks", {bus.wr_ack, bus.rd_ack}, 2'b11);
            tick();
            wr_n++; rd_n++;
            check("ilv_count", bus.count_o, wr_n - rd_n);
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        check("ilv_rsel_end", bus.rsel_o, 1);
        check("ilv_e_end", bus.e_o, 32'hFFF1);

        // Flush from count 5, pulsed together with a write request.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.wr_req = 1'b1;
            tick();
        end
        check("pre_flush_count", bus.count_o, 5);
        bus.flush_i = 1'b1;
        #1;
        check("flush_wr_ack", bus.wr_ack, 0);
        check("flush_we", bus.we_o, 0);
        tick();
        bus.flush_i = 1'b0; bus.wr_req = 1'b0;
        for (int k = 0; k < N; k++) begin
            // A second flush request mid-sweep must not restart it.
            bus.flush_i = (k == 8);
            bus.wr_req  = (k == 3);
            #1;
            check("sweep_busy", bus.busy_o, 1);
            check("sweep_clr", bus.clr_o, 32'(1) << k);
            check("sweep_wr_ack", bus.wr_ack, 0);
            tick();
        end
        bus.flush_i = 1'b0; bus.wr_req = 1'b0;
        check("post_flush_busy", bus.busy_o, 0);
        check("post_flush_clr", bus.clr_o, 0);
        check("post_flush_e", bus.e_o, 32'hFFFF);
        check("post_flush_count", bus.count_o, 0);
        check("post_flush_empty", bus.empty_o, 1);
        check("post_flush_rsel", bus.rsel_o, 0);
        bus.wr_req = 1'b1;
        #1;
        check("post_flush_we", bus.we_o, 32'h0001);
        tick();
        bus.wr_req = 1'b0;

        // Reset on the 4th sweep cycle aborts the flush.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.wr_req = 1'b1;
            tick();
        end
        bus.wr_req = 1'b0;
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        tick();
        tick();
        tick();
        check("abort_busy_before", bus.busy_o, 1);
        check("abort_clr_before", bus.clr_o, 32'h0008);
        rst = 1'b1;
        #1;
        check("abort_clr_in_rst", bus.clr_o, 0);
        tick();
        rst = 1'b0;
        check("abort_busy", bus.busy_o, 0);
        check("abort_clr", bus.clr_o, 0);
        check("abort_e", bus.e_o, 32'hFFFF);
        check("abort_count", bus.count_o, 0);
        bus.wr_req = 1'b1;
        #1;
        check("abort_idle_wr_ack", bus.wr_ack, 1);
        check("abort_idle_we", bus.we_o, 32'h0001);
        tick();
        bus.wr_req = 1'b0;
        check("abort_idle_count", bus.count_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
